reg_bus_router: RTL and testbench
=================================

Name: reg_bus_router

Overview:
- Routes the simple register interface produced by axi_lite_slave (address, in_rdy/ack, out_req/rdy, invalid_addr) to NUM_CLIENTS register-bank clients.
- Decodes the upper address bits to select one client and sequences a single outstanding access at a time.
- Turns unmapped addresses, client-flagged errors and unresponsive clients into a well-formed upstream response with invalid_addr set.
- Sits directly below axi_lite_slave in every multi-bank core.

Parameters:
- ADDR_WIDTH, 16, width of register address.
- NUM_CLIENTS, 4, number of downstream register banks (1..16).
- REGION_BITS, 8, low address bits forwarded to a client; client index = address >> REGION_BITS.
- TIMEOUT_CYCLES, 255, cycles to wait for client ack/rdy before aborting (>=2).

Ports:
- clk  in  1  register interface clock.
- rst  in  1  asynchronous, active-high reset.
- i_reg_address  in  ADDR_WIDTH  upstream address.
- i_reg_in_rdy  in  1  upstream write request; held until o_reg_in_ack.
- i_reg_in_data  in  32  upstream write data.
- o_reg_in_ack  out  1  write-complete pulse.
- i_reg_out_req  in  1  upstream read request; held until o_reg_out_rdy.
- o_reg_out_rdy  out  1  read-complete pulse.
- o_reg_out_data  out  32  read data, valid with o_reg_out_rdy.
- o_reg_invalid_addr  out  1  error flag, pulsed with the ack or rdy.
- o_cli_address  out  REGION_BITS  client-local address.
- o_cli_in_data  out  32  write data to all clients.
- o_cli_in_rdy  out  NUM_CLIENTS  one-hot write strobe.
- i_cli_in_ack  in  NUM_CLIENTS  per-client write ack.
- o_cli_out_req  out  NUM_CLIENTS  one-hot read strobe.
- i_cli_out_rdy  in  NUM_CLIENTS  per-client read ready.
- i_cli_out_data  in  32*NUM_CLIENTS  packed read data; client i occupies [32*i +: 32].
- i_cli_invalid_addr  in  NUM_CLIENTS  client error flag, sampled with that client's ack or rdy.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE.
  - Timeout counter is 0.
- States: IDLE, WR_WAIT, RD_WAIT, RESP, HOLD.
- IDLE:
  - i_reg_in_rdy has priority over i_reg_out_req when both are high.
  - On acceptance, latch the address, data and client index.
  - If the index is >= NUM_CLIENTS, go to RESP with error=1 and data=0; no client strobe is issued.
  - Otherwise, in the next cycle assert the selected o_cli_in_rdy (WR_WAIT) or o_cli_out_req (RD_WAIT).
  - o_cli_address and o_cli_in_data are registered and remain stable for the whole access.
- WR_WAIT / RD_WAIT:
  - The strobe is held high as a level.
  - Each cycle, sample only the selected client's ack or rdy; all other clients' ack/rdy are ignored.
  - On the selected ack/rdy:
    - drop the strobe the next cycle;
    - capture i_cli_invalid_addr[sel], plus the client's read data for reads;
    - go to RESP.
  - The counter increments each waiting cycle. When it reaches TIMEOUT_CYCLES without an ack/rdy:
    - drop the strobe;
    - error=1, data=0;
    - go to RESP.
  - An ack/rdy arriving in the same cycle the counter expires wins; no error is reported.
- RESP:
  - One-cycle pulse of o_reg_in_ack (write) or o_reg_out_rdy (read).
  - o_reg_invalid_addr = error in the same cycle; o_reg_out_data is valid in the same cycle.
  - Then go to HOLD.
- HOLD:
  - One cycle that ignores i_reg_in_rdy and i_reg_out_req, so a still-held level is not re-accepted.
  - Then go to IDLE.
- Latency, valid client:
  - upstream request seen in cycle 0, client strobe in cycle 1;
  - client responds in cycle k, upstream ack/rdy in cycle k+1.
- Latency, unmapped address: upstream response in cycle 1.
- o_reg_out_data holds its last value outside RESP; it is zero only after reset, on errors, or on writes.
- Asynchronous reset mid-access:
  - all strobes drop immediately and no response is issued;
  - the upstream master is reset by the same rst.
- Only one client strobe is ever high at a time.

Optional Feature:
- Macro REG_BUS_ROUTER_STATS_EN.
- Defined:
  - Adds ports o_timeout_count (16-bit) and o_last_fault_addr (ADDR_WIDTH-bit), both reset to 0.
  - o_timeout_count increments on every timeout and saturates at 0xFFFF.
  - o_last_fault_addr captures the full upstream address on every error response: unmapped, client-flagged or timeout.
- Undefined:
  - The ports are absent and no counter logic is generated.
  - Core behaviour is otherwise identical.

Decomposition:
- Shared package reg_bus_pkg:
  - state encoding localparams (IDLE, WR_WAIT, RD_WAIT, RESP, HOLD);
  - RESP_ERR/RESP_OK constants;
  - the function computing client index width from NUM_CLIENTS.
- One natural sub-module, reg_bus_timeout:
  - loadable down-counter with clear and an expire output;
  - reused by other cores for access watchdogs.

Test Plan:
- Write 0xDEADBEEF to 0x0104 with client 1 acking after 3 cycles -> o_cli_in_rdy=4'b0010 for cycles 1..3, o_cli_address=0x04, o_reg_in_ack pulse in cycle 4, invalid=0.
- Read 0x0208 with client 2 rdy in cycle 1 carrying 0x12345678 -> o_reg_out_rdy in cycle 2, o_reg_out_data=0x12345678, invalid=0.
- Read 0x0500 (NUM_CLIENTS=4) -> no client strobe, o_reg_out_rdy in cycle 1, data=0, invalid=1.
- Write to client 3, which never acks (TIMEOUT_CYCLES=8) -> strobe drops after 8 cycles, o_reg_in_ack with invalid=1; with STATS_EN, o_timeout_count=1 and o_last_fault_addr=0x03xx.
- i_reg_in_rdy and i_reg_out_req both high and held -> write serviced first, one HOLD cycle, no duplicate write; client 0 asserting ack while client 1 is selected is ignored.
- Assert rst during RD_WAIT -> all outputs 0 asynchronously, no o_reg_out_rdy, next access proceeds normally.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types and helpers for the register-bus router and its timeout counter.
package reg_bus_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_WAIT = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        WR_WAIT = ST_WR_WAIT,
        RD_WAIT = ST_RD_WAIT,
        RESP    = ST_RESP,
        HOLD    = ST_HOLD
    } state_e;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_bus_timeout.sv
// Loadable down-counter watchdog: expire_o is high in an enabled cycle once the count has run out.
module reg_bus_timeout #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = load_val_i;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/reg_bus_router.sv
// Routes one upstream register access at a time to the client selected by address >> REGION_BITS.
// Optional statistics ports are enabled by defining REG_BUS_ROUTER_STATS_EN.
module reg_bus_router
    import reg_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int NUM_CLIENTS    = 4,
    parameter int REGION_BITS    = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     i_reg_address,
    input  logic                      i_reg_in_rdy,
    input  logic [31:0]               i_reg_in_data,
    output logic                      o_reg_in_ack,
    input  logic                      i_reg_out_req,
    output logic                      o_reg_out_rdy,
    output logic [31:0]               o_reg_out_data,
    output logic                      o_reg_invalid_addr,
    output logic [REGION_BITS-1:0]    o_cli_address,
    output logic [31:0]               o_cli_in_data,
    output logic [NUM_CLIENTS-1:0]    o_cli_in_rdy,
    input  logic [NUM_CLIENTS-1:0]    i_cli_in_ack,
    output logic [NUM_CLIENTS-1:0]    o_cli_out_req,
    input  logic [NUM_CLIENTS-1:0]    i_cli_out_rdy,
    input  logic [32*NUM_CLIENTS-1:0] i_cli_out_data,
    input  logic [NUM_CLIENTS-1:0]    i_cli_invalid_addr
`ifdef REG_BUS_ROUTER_STATS_EN
    ,
    output logic [15:0]               o_timeout_count,
    output logic [ADDR_WIDTH-1:0]     o_last_fault_addr
`endif
);

    localparam int SEL_W = idx_width(NUM_CLIENTS);
    localparam int UP_W  = ADDR_WIDTH - REGION_BITS;
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e                 state_q;
    logic [SEL_W-1:0]       sel_q;
    logic [REGION_BITS-1:0] cli_addr_q;
    logic [31:0]            cli_data_q;
    logic [NUM_CLIENTS-1:0] in_rdy_q, out_req_q;
    logic                   in_ack_q, out_rdy_q, inv_q;
    logic [31:0]            rdata_q;

    logic [UP_W-1:0]        req_idx;
    logic                   req_mapped, go, is_wait, sel_hit, sel_inv, expire;
    logic [NUM_CLIENTS-1:0] req_onehot;
    logic [31:0]            sel_data;

    assign req_idx    = i_reg_address[ADDR_WIDTH-1:REGION_BITS];
    assign req_mapped = 32'(req_idx) < 32'(NUM_CLIENTS);
    assign req_onehot = NUM_CLIENTS'(1) << req_idx;
    assign go         = i_reg_in_rdy | i_reg_out_req;
    assign is_wait    = (state_q == WR_WAIT) || (state_q == RD_WAIT);
    // Only the selected client's handshake is looked at; the others are don't-care.
    assign sel_hit    = (state_q == WR_WAIT) ? i_cli_in_ack[sel_q] : i_cli_out_rdy[sel_q];
    assign sel_inv    = i_cli_invalid_addr[sel_q];
    assign sel_data   = i_cli_out_data[32*int'(sel_q) +: 32];

    reg_bus_timeout #(.CNT_W(TO_W)) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q == RESP),
        .load_i     ((state_q == IDLE) && go && req_mapped),
        .load_val_i (TO_W'(TIMEOUT_CYCLES - 1)),
        .en_i       (is_wait),
        .expire_o   (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cli_addr_q <= '0;
            cli_data_q <= '0;
            in_rdy_q   <= '0;
            out_req_q  <= '0;
            in_ack_q   <= 1'b0;
            out_rdy_q  <= 1'b0;
            inv_q      <= RESP_OK;
            rdata_q    <= '0;
        end else begin
            in_ack_q  <= 1'b0;
            out_rdy_q <= 1'b0;
            inv_q     <= RESP_OK;
            case (state_q)
                IDLE: if (go) begin
                    sel_q      <= SEL_W'(req_idx);
                    cli_addr_q <= i_reg_address[REGION_BITS-1:0];
                    cli_data_q <= i_reg_in_data;
                    if (!req_mapped) begin
                        state_q   <= RESP;
                        in_ack_q  <= i_reg_in_rdy;
                        out_rdy_q <= !i_reg_in_rdy;
                        inv_q     <= RESP_ERR;
                        rdata_q   <= '0;
                    end else if (i_reg_in_rdy) begin
                        state_q  <= WR_WAIT;
                        in_rdy_q <= req_onehot;
                    end else begin
                        state_q   <= RD_WAIT;
                        out_req_q <= req_onehot;
                    end
                end
                WR_WAIT: if (sel_hit || expire) begin
                    state_q  <= RESP;
                    in_rdy_q <= '0;
                    in_ack_q <= 1'b1;
                    inv_q    <= sel_hit ? sel_inv : RESP_ERR;
                    rdata_q  <= '0;
                end
                RD_WAIT: if (sel_hit || expire) begin
                    state_q   <= RESP;
                    out_req_q <= '0;
                    out_rdy_q <= 1'b1;
                    inv_q     <= sel_hit ? sel_inv : RESP_ERR;
                    rdata_q   <= sel_hit ? sel_data : '0;
                end
                // HOLD keeps a still-asserted request level from being taken twice.
                RESP:    state_q <= HOLD;
                HOLD:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_reg_in_ack       = in_ack_q;
    assign o_reg_out_rdy      = out_rdy_q;
    assign o_reg_out_data     = rdata_q;
    assign o_reg_invalid_addr = inv_q;
    assign o_cli_address      = cli_addr_q;
    assign o_cli_in_data      = cli_data_q;
    assign o_cli_in_rdy       = in_rdy_q;
    assign o_cli_out_req      = out_req_q;

`ifdef REG_BUS_ROUTER_STATS_EN
    logic [15:0]           to_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q, fault_q;
    logic                  unmapped_ev, timeout_ev, flag_ev;

    assign unmapped_ev = (state_q == IDLE) && go && !req_mapped;
    assign timeout_ev  = is_wait && !sel_hit && expire;
    assign flag_ev     = is_wait && sel_hit && sel_inv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            addr_q   <= '0;
            fault_q  <= '0;
        end else begin
            if ((state_q == IDLE) && go)
                addr_q <= i_reg_address;
            if (unmapped_ev)
                fault_q <= i_reg_address;
            else if (timeout_ev || flag_ev)
                fault_q <= addr_q;
            if (timeout_ev && to_cnt_q != 16'hFFFF)
                to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    assign o_timeout_count   = to_cnt_q;
    assign o_last_fault_addr = fault_q;
`endif

endmodule

// File: tb/tb_reg_bus_router.sv
// Directed bench for reg_bus_router with a transaction-level reference model checked every cycle.
module tb_reg_bus_router;

    localparam int AW = 16;
    localparam int NC = 4;
    localparam int RB = 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     i_reg_address;
    logic              i_reg_in_rdy;
    logic [31:0]       i_reg_in_data;
    logic              o_reg_in_ack;
    logic              i_reg_out_req;
    logic              o_reg_out_rdy;
    logic [31:0]       o_reg_out_data;
    logic              o_reg_invalid_addr;
    logic [RB-1:0]     o_cli_address;
    logic [31:0]       o_cli_in_data;
    logic [NC-1:0]     o_cli_in_rdy;
    logic [NC-1:0]     i_cli_in_ack;
    logic [NC-1:0]     o_cli_out_req;
    logic [NC-1:0]     i_cli_out_rdy;
    logic [32*NC-1:0]  i_cli_out_data;
    logic [NC-1:0]     i_cli_invalid_addr;
`ifdef REG_BUS_ROUTER_STATS_EN
    logic [15:0]       o_timeout_count;
    logic [AW-1:0]     o_last_fault_addr;
`endif

    reg_bus_router #(
        .ADDR_WIDTH(AW), .NUM_CLIENTS(NC), .REGION_BITS(RB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_reg_address      (i_reg_address),
        .i_reg_in_rdy       (i_reg_in_rdy),
        .i_reg_in_data      (i_reg_in_data),
        .o_reg_in_ack       (o_reg_in_ack),
        .i_reg_out_req      (i_reg_out_req),
        .o_reg_out_rdy      (o_reg_out_rdy),
        .o_reg_out_data     (o_reg_out_data),
        .o_reg_invalid_addr (o_reg_invalid_addr),
        .o_cli_address      (o_cli_address),
        .o_cli_in_data      (o_cli_in_data),
        .o_cli_in_rdy       (o_cli_in_rdy),
        .i_cli_in_ack       (i_cli_in_ack),
        .o_cli_out_req      (o_cli_out_req),
        .i_cli_out_rdy      (i_cli_out_rdy),
        .i_cli_out_data     (i_cli_out_data),
        .i_cli_invalid_addr (i_cli_invalid_addr)
`ifdef REG_BUS_ROUTER_STATS_EN
        ,
        .o_timeout_count    (o_timeout_count),
        .o_last_fault_addr  (o_last_fault_addr)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction model: what one access must look like, cycle by cycle, relative to its start.
    bit          m_on = 1'b0;
    bit          m_wr, m_map, m_err;
    int          m_t0, m_send, m_resp, m_sel;
    logic [31:0] m_data, m_wdata;
    logic [31:0] m_hold = '0;
    logic [RB-1:0] m_caddr;

    int          g_t0, cap_cyc, n_strobe;
    logic [31:0] cap_data;
    logic        cap_inv;
    logic [RB-1:0] cap_caddr;

    function automatic void plan(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                                 input int d, input bit cerr, input logic [31:0] cdata);
        int idx;
        idx     = int'(addr >> RB);
        m_on    = 1'b1;
        m_t0    = cyc;
        m_wr    = wr;
        m_sel   = idx;
        m_caddr = addr[RB-1:0];
        m_wdata = wd;
        m_map   = idx < NC;
        if (!m_map) begin
            m_send = m_t0; m_resp = m_t0 + 1; m_err = 1'b1; m_data = '0;
        end else if (d >= 1 && d <= TO) begin
            m_send = m_t0 + d; m_resp = m_t0 + d + 1; m_err = cerr; m_data = wr ? 32'h0 : cdata;
        end else begin
            m_send = m_t0 + TO; m_resp = m_t0 + TO + 1; m_err = 1'b1; m_data = '0;
        end
    endfunction

    always @(negedge clk) begin : cmp
        logic [NC-1:0] es;
        bit in_resp;
        if (rst) begin
            chk("rst_cli_in_rdy", 32'(o_cli_in_rdy), 32'h0);
            chk("rst_cli_out_req", 32'(o_cli_out_req), 32'h0);
            chk("rst_in_ack", 32'(o_reg_in_ack), 32'h0);
            chk("rst_out_rdy", 32'(o_reg_out_rdy), 32'h0);
            chk("rst_invalid", 32'(o_reg_invalid_addr), 32'h0);
            chk("rst_out_data", o_reg_out_data, 32'h0);
        end else begin
            es = '0;
            if (m_on && m_map && cyc >= m_t0 + 1 && cyc <= m_send)
                es = NC'(1) << m_sel;
            in_resp = m_on && (cyc == m_resp);
            chk("cli_in_rdy", 32'(o_cli_in_rdy), 32'(m_wr ? es : '0));
            chk("cli_out_req", 32'(o_cli_out_req), 32'(m_wr ? '0 : es));
            chk("reg_in_ack", 32'(o_reg_in_ack), 32'(in_resp && m_wr));
            chk("reg_out_rdy", 32'(o_reg_out_rdy), 32'(in_resp && !m_wr));
            chk("reg_invalid", 32'(o_reg_invalid_addr), 32'(in_resp && m_err));
            chk("reg_out_data", o_reg_out_data, in_resp ? m_data : m_hold);
            if (es != '0) begin
                chk("cli_address", 32'(o_cli_address), 32'(m_caddr));
                if (m_wr)
                    chk("cli_in_data", o_cli_in_data, m_wdata);
            end
            if (in_resp)
                m_hold = m_data;
        end
        if (o_reg_in_ack || o_reg_out_rdy) begin
            cap_cyc  = cyc;
            cap_data = o_reg_out_data;
            cap_inv  = o_reg_invalid_addr;
        end
        if ((|o_cli_in_rdy) || (|o_cli_out_req)) begin
            n_strobe++;
            cap_caddr = o_cli_address;
        end
    end

    // d: cycles after the request until the client answers (0 = never); keep: hold request one extra cycle.
    task automatic xact(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd, input int d,
                        input bit cerr, input logic [31:0] cdata, input bit keep, input logic [NC-1:0] noise);
        int idx;
        idx = int'(addr >> RB);
        plan(wr, addr, wd, d, cerr, cdata);
        g_t0 = cyc; n_strobe = 0; cap_cyc = -1;
        i_reg_address = addr;
        i_reg_in_data = wd;
        if (wr) i_reg_in_rdy = 1'b1; else i_reg_out_req = 1'b1;
        while (cyc <= m_resp + 1) begin
            i_cli_in_ack = '0; i_cli_out_rdy = '0; i_cli_invalid_addr = '0; i_cli_out_data = '0;
            if (cyc < m_resp) begin
                if (wr) i_cli_in_ack = noise; else i_cli_out_rdy = noise;
                i_cli_invalid_addr = noise;
            end
            if (idx < NC && d >= 1 && cyc == g_t0 + d) begin
                if (wr) i_cli_in_ack[idx] = 1'b1; else i_cli_out_rdy[idx] = 1'b1;
                i_cli_invalid_addr[idx] = cerr;
                i_cli_out_data[idx*32 +: 32] = cdata;
            end
            if (cyc == m_resp + 1 && !keep) begin
                if (wr) i_reg_in_rdy = 1'b0; else i_reg_out_req = 1'b0;
            end
            @(posedge clk); #1;
        end
        i_cli_in_ack = '0; i_cli_out_rdy = '0; i_cli_invalid_addr = '0; i_cli_out_data = '0;
        if (wr) i_reg_in_rdy = 1'b0; else i_reg_out_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_reg_address = '0; i_reg_in_rdy = 1'b0; i_reg_in_data = '0; i_reg_out_req = 1'b0;
        i_cli_in_ack = '0; i_cli_out_rdy = '0; i_cli_out_data = '0; i_cli_invalid_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_data", o_reg_out_data, 32'h0);
        chk("reset_cli_in_rdy", 32'(o_cli_in_rdy), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        xact(1'b1, 16'h0104, 32'hDEADBEEF, 3, 1'b0, 32'h0, 1'b0, '0);
        chk("wr_strobe_cycles", 32'(n_strobe), 32'd3);
        chk("wr_ack_latency", 32'(cap_cyc - g_t0), 32'd4);
        chk("wr_invalid", 32'(cap_inv), 32'h0);
        chk("wr_cli_address", 32'(cap_caddr), 32'h04);

        xact(1'b0, 16'h0208, 32'h0, 1, 1'b0, 32'h12345678, 1'b0, '0);
        chk("rd_latency", 32'(cap_cyc - g_t0), 32'd2);
        chk("rd_data", cap_data, 32'h12345678);
        chk("rd_invalid", 32'(cap_inv), 32'h0);

        xact(1'b0, 16'h0500, 32'h0, 0, 1'b0, 32'h0, 1'b0, '0);
        chk("unmapped_latency", 32'(cap_cyc - g_t0), 32'd1);
        chk("unmapped_data", cap_data, 32'h0);
        chk("unmapped_invalid", 32'(cap_inv), 32'h1);
        chk("unmapped_strobes", 32'(n_strobe), 32'd0);
`ifdef REG_BUS_ROUTER_STATS_EN
        chk("stats_fault_unmapped", 32'(o_last_fault_addr), 32'h0500);
`endif

        xact(1'b1, 16'h0312, 32'hCAFEF00D, 0, 1'b0, 32'h0, 1'b0, '0);
        chk("timeout_strobe_cycles", 32'(n_strobe), 32'd8);
        chk("timeout_latency", 32'(cap_cyc - g_t0), 32'd9);
        chk("timeout_invalid", 32'(cap_inv), 32'h1);
`ifdef REG_BUS_ROUTER_STATS_EN
        chk("stats_timeout_count", 32'(o_timeout_count), 32'd1);
        chk("stats_fault_timeout", 32'(o_last_fault_addr), 32'h0312);
`endif

        xact(1'b0, 16'h0320, 32'h0, TO, 1'b0, 32'hA5A50F0F, 1'b0, '0);
        chk("late_rdy_latency", 32'(cap_cyc - g_t0), 32'(TO + 1));
        chk("late_rdy_invalid", 32'(cap_inv), 32'h0);
        chk("late_rdy_data", cap_data, 32'hA5A50F0F);

        xact(1'b1, 16'h0210, 32'h00000001, 2, 1'b1, 32'h0, 1'b0, '0);
        chk("cli_err_invalid", 32'(cap_inv), 32'h1);
`ifdef REG_BUS_ROUTER_STATS_EN
        chk("stats_fault_client", 32'(o_last_fault_addr), 32'h0210);
        chk("stats_timeout_kept", 32'(o_timeout_count), 32'd1);
`endif

        i_reg_out_req = 1'b1;
        xact(1'b1, 16'h0104, 32'h55AA55AA, 2, 1'b0, 32'h0, 1'b1, 4'b0001);
        chk("prio_wr_strobes", 32'(n_strobe), 32'd2);
        chk("prio_wr_invalid", 32'(cap_inv), 32'h0);
        xact(1'b0, 16'h0104, 32'h0, 1, 1'b0, 32'h0BADCAFE, 1'b0, '0);
        chk("prio_rd_data", cap_data, 32'h0BADCAFE);
        chk("prio_rd_latency", 32'(cap_cyc - g_t0), 32'd2);

        plan(1'b0, 16'h0210, 32'h0, 0, 1'b0, 32'h0);
        g_t0 = cyc;
        i_reg_address = 16'h0210;
        i_reg_out_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_strobe", 32'(o_cli_out_req), 32'h4);
        #2 rst = 1'b1;
        #1;
        m_on = 1'b0;
        m_hold = '0;
        chk("async_rst_out_req", 32'(o_cli_out_req), 32'h0);
        chk("async_rst_out_rdy", 32'(o_reg_out_rdy), 32'h0);
        chk("async_rst_out_data", o_reg_out_data, 32'h0);
        chk("async_rst_cli_addr", 32'(o_cli_address), 32'h0);
`ifdef REG_BUS_ROUTER_STATS_EN
        chk("async_rst_timeout_count", 32'(o_timeout_count), 32'h0);
        chk("async_rst_fault_addr", 32'(o_last_fault_addr), 32'h0);
`endif
        i_reg_out_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        xact(1'b1, 16'h0208, 32'h77778888, 1, 1'b0, 32'h0, 1'b0, '0);
        chk("post_rst_latency", 32'(cap_cyc - g_t0), 32'd2);
        chk("post_rst_invalid", 32'(cap_inv), 32'h0);

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
